// File: rtl/bp_packer.sv
// bp_packer: stream upsizer that gathers RATIO consecutive DATAW-bit beats into one
// DATAW*RATIO-bit word, with ready/valid backpressure on both sides.
// Beat k of a word lands in data_o[k*DATAW +: DATAW]; the output word is registered.
// Optional feature macro: BP_PACKER_LAST_EN (adds last_i, last_o, keep_o so that a
// beat flagged with last_i closes a partial word early).
//
// state | meaning
// r_cnt | lane that the next accepted beat is written into (0..RATIO-1)
// r_acc | lanes 0..r_cnt-1 of the word being gathered, upper lanes zero
// r_valid | r_data holds a word that downstream has not yet taken
module bp_packer #(
  parameter int DATAW = 8,
  parameter int RATIO = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [DATAW-1:0]       data_i,
  input  logic                   valid_i,
`ifdef BP_PACKER_LAST_EN
  input  logic                   last_i,
  output logic                   last_o,
  output logic [RATIO-1:0]       keep_o,
`endif
  output logic                   ready_o,
  output logic [DATAW*RATIO-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  localparam int CNTW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int OUTW = DATAW * RATIO;

  logic [CNTW-1:0] r_cnt;
  logic [OUTW-1:0] r_acc;
  logic [OUTW-1:0] r_data;
  logic            r_valid;

  logic            w_closing;
  logic            w_accept;
  logic [OUTW-1:0] w_word;
  logic [OUTW-1:0] w_acc_next;

`ifdef BP_PACKER_LAST_EN
  logic             r_last;
  logic [RATIO-1:0] r_keep;
  logic [RATIO-1:0] w_keep;

  assign w_closing = (r_cnt == CNTW'(RATIO - 1)) || last_i;
`else
  assign w_closing = (r_cnt == CNTW'(RATIO - 1));
`endif

  // A closing beat may only be taken when the output register is free or being emptied;
  // non-closing beats go to the accumulator and never need to wait.
  assign ready_o  = w_closing ? (~r_valid | ready_i) : 1'b1;
  assign w_accept = valid_i & ready_o;

  // Merge the incoming beat into lane r_cnt; lanes above r_cnt are already zero in r_acc.
  always_comb begin
    w_word     = r_acc;
    w_acc_next = r_acc;
    for (int k = 0; k < RATIO; k++) begin
      if (k == int'(r_cnt)) begin
        w_word[k*DATAW +: DATAW]     = data_i;
        w_acc_next[k*DATAW +: DATAW] = data_i;
      end
    end
  end

`ifdef BP_PACKER_LAST_EN
  // Lanes 0..r_cnt hold real beats in the word closed by this beat.
  always_comb begin
    w_keep = '0;
    for (int k = 0; k < RATIO; k++) begin
      w_keep[k] = (k <= int'(r_cnt));
    end
  end
`endif

  // Gathering side: lane counter and accumulator, cleared whenever a word closes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      if (w_closing) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_cnt <= r_cnt + CNTW'(1);
        r_acc <= w_acc_next;
      end
    end
  end

  // Output register: loaded by a closing beat (even in the cycle the old word is taken),
  // otherwise held while stalled and invalidated once taken.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_data  <= '0;
      r_valid <= 1'b0;
`ifdef BP_PACKER_LAST_EN
      r_last  <= 1'b0;
      r_keep  <= '0;
`endif
    end else if (w_accept && w_closing) begin
      r_data  <= w_word;
      r_valid <= 1'b1;
`ifdef BP_PACKER_LAST_EN
      r_last  <= last_i;
      r_keep  <= w_keep;
`endif
    end else if (r_valid && ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
`ifdef BP_PACKER_LAST_EN
  assign last_o  = r_last;
  assign keep_o  = r_keep;
`endif

endmodule
